// File: rtl/serial_sub_pkg.sv
// +--------------------------------------------------------------+
// | serial_sub_pkg: state encoding and sizing helpers for         |
// | serial_sub.                          Revision: 1.0            |
// +--------------------------------------------------------------+
`default_nettype none

package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // A one-digit operation still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_sub_cell.sv
// +--------------------------------------------------------------+
// | full_sub_cell: one-bit combinational full subtractor.         |
// |                                      Revision: 1.0            |
// +--------------------------------------------------------------+
`default_nettype none

module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

`default_nettype wire

// File: rtl/serial_sub.sv
// +--------------------------------------------------------------+
// | serial_sub: digit-serial a - b - bin, LSB first, with a       |
// | start/busy/done handshake. Macro SERIAL_SUB_OVF_EN adds ovf.  |
// |                                      Revision: 1.0            |
// +--------------------------------------------------------------+
`default_nettype none

module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = num_digits(WIDTH, DIGIT);
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  if (WIDTH < 2) begin : g_width_check
    $error("serial_sub: WIDTH must be at least 2");
  end
  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_digit_check
    $error("serial_sub: DIGIT must divide WIDTH");
  end

  state_t state, state_next;

  logic [WIDTH-1:0] a_r, b_r, res_r, res_full;
  logic             borrow_r;
  logic [CNT_W-1:0] cnt;
  logic [DIGIT-1:0] a_slice, b_slice, d_slice;
  logic [DIGIT:0]   chain;
  logic             accept, last;
  int               base;

  assign accept = start && (state != RUN);
  assign last   = (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Current digit of the operands, and the result with this digit merged in.
  always_comb begin
    base     = int'(cnt) * DIGIT;
    a_slice  = a_r[base +: DIGIT];
    b_slice  = b_r[base +: DIGIT];
    res_full = res_r;
    res_full[base +: DIGIT] = d_slice;
  end

  assign chain[0] = borrow_r;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    full_sub_cell u_cell (
      .x  (a_slice[i]),
      .y  (b_slice[i]),
      .bi (chain[i]),
      .d  (d_slice[i]),
      .bo (chain[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      res_r    <= '0;
      borrow_r <= 1'b0;
      cnt      <= '0;
      diff     <= '0;
      bout     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf      <= 1'b0;
`endif
    end else if (accept) begin
      a_r      <= a;
      b_r      <= b;
      borrow_r <= bin;
      cnt      <= '0;
    end else if (state == RUN) begin
      res_r    <= res_full;
      borrow_r <= chain[DIGIT];
      cnt      <= cnt + 1'b1;
      // Outputs change only on the edge that enters DONE.
      if (last) begin
        diff <= res_full;
        bout <= chain[DIGIT];
`ifdef SERIAL_SUB_OVF_EN
        ovf  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (res_full[WIDTH-1] != a_r[WIDTH-1]);
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: an 8-bit/1-digit and a 16-bit/4-digit instance
// checked against an arithmetic reference model.
`default_nettype none

module tb_serial_sub;

  logic clk = 1'b0;
  logic rst_n;

  logic        start8, bin8, busy8, done8, bout8, ovf8;
  logic [7:0]  a8, b8, diff8;
  logic        start16, bin16, busy16, done16, bout16, ovf16;
  logic [15:0] a16, b16, diff16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_sub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start16),
    .a     (a16),
    .b     (b16),
    .bin   (bin16),
    .busy  (busy16),
    .done  (done16),
    .diff  (diff16),
    .bout  (bout16)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf16)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf8  = 1'b0;
  assign ovf16 = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input int w, input longint ua, input longint ub, input logic bi,
                       output logic [31:0] d, output logic bo, output logic ov);
    longint sa, sb, r, sr, m;
    m  = longint'(1) << w;
    r  = ua - ub - longint'(bi);
    d  = 32'(((r % m) + m) % m);
    bo = (ua < ub + longint'(bi));
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    sr = sa - sb - longint'(bi);
    ov = (sr < -(m / 2)) || (sr > (m / 2) - 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one 8-bit operation; poke_at >= 0 pulses a stray start in RUN.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbi, input int poke_at);
    logic [31:0] ed;
    logic eb, eo;
    int n;
    model(8, longint'(ta), longint'(tb), tbi, ed, eb, eo);
    a8 = ta; b8 = tb; bin8 = tbi; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("busy8_after_start", 32'(busy8), 32'd1);
    n = 0;
    while (!done8 && n < 20) begin
      if (n == poke_at) begin
        start8 = 1'b1; a8 = ~ta; b8 = 8'h00; bin8 = 1'b1;
      end
      tick();
      start8 = 1'b0;
      n++;
    end
    chk("latency8", 32'(n), 32'd8);
    chk("done8", 32'(done8), 32'd1);
    chk("busy8_in_done", 32'(busy8), 32'd0);
    chk("diff8", 32'(diff8), ed);
    chk("bout8", 32'(bout8), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf8", 32'(ovf8), 32'(eo));
`endif
  endtask

  task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic tbi);
    logic [31:0] ed;
    logic eb, eo;
    int n;
    model(16, longint'(ta), longint'(tb), tbi, ed, eb, eo);
    a16 = ta; b16 = tb; bin16 = tbi; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    chk("busy16_after_start", 32'(busy16), 32'd1);
    n = 0;
    while (!done16 && n < 20) begin
      tick();
      n++;
    end
    chk("latency16", 32'(n), 32'd4);
    chk("done16", 32'(done16), 32'd1);
    chk("diff16", 32'(diff16), ed);
    chk("bout16", 32'(bout16), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf16", 32'(ovf16), 32'(eo));
`endif
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
    tick(); tick();
    chk("reset_busy8", 32'(busy8), 32'd0);
    chk("reset_done8", 32'(done8), 32'd0);
    chk("reset_diff8", 32'(diff8), 32'd0);
    chk("reset_bout8", 32'(bout8), 32'd0);
    chk("reset_ovf8", 32'(ovf8), 32'd0);
    chk("reset_diff16", 32'(diff16), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed vectors, each issued from IDLE.
    op8(8'h05, 8'h03, 1'b0, -1); tick();
    op8(8'h00, 8'h01, 1'b0, -1); tick();
    op8(8'h80, 8'h00, 1'b1, -1); tick();
    op8(8'h7F, 8'hFF, 1'b0, -1); tick();
    op8(8'hFF, 8'hFF, 1'b1, -1); tick();

    // Stray start in RUN ignored, then back-to-back start in the done cycle.
    op8(8'h33, 8'h11, 1'b0, 3);
    op8(8'h10, 8'h01, 1'b0, -1);
    tick();
    chk("idle_after_done", 32'(busy8 | done8), 32'd0);

    // Reset partway through an operation.
    op8(8'h05, 8'h03, 1'b0, -1); tick();
    a8 = 8'h44; b8 = 8'h22; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midreset_diff8", 32'(diff8), 32'd0);
    chk("midreset_bout8", 32'(bout8), 32'd0);
    chk("midreset_busy8", 32'(busy8), 32'd0);
    chk("midreset_done8", 32'(done8), 32'd0);
    chk("midreset_ovf8", 32'(ovf8), 32'd0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 || busy8) seen++;
    end
    chk("no_done_after_reset", 32'(seen), 32'd0);

    // Wide-digit instance.
    op16(16'h1234, 16'h0235, 1'b0);
    op16(16'h0000, 16'h0000, 1'b1);
    tick();
    op16(16'h8000, 16'h0001, 1'b0);
    tick();

    // Randomised operations, with random idle gaps or back-to-back.
    for (int i = 0; i < 12; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), -1);
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
    for (int i = 0; i < 12; i++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) tick();
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_sub.md
# serial_sub

Multi-cycle, parametrised N-bit subtractor that computes `diff = a - b - bin` DIGIT bits per clock, LSB first, by iterating a combinational full-subtractor cell across operand digits. It generalises the single-bit full subtractor in the arithmetic library into an area-lean word-level unit. It uses a start/busy/done handshake and sits behind any controller that can tolerate WIDTH/DIGIT cycles of latency.

## Interface
- WIDTH, 8, operand and result width in bits; must be at least 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when not busy.
- a  input  WIDTH  minuend, captured on accepted start.
- b  input  WIDTH  subtrahend, captured on accepted start.
- bin  input  1  borrow-in, captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when result is valid.
- diff  output  WIDTH  difference; holds until the next completion.
- bout  output  1  borrow-out of the MSB; holds like diff.
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: start=1 captures a, b and bin, clears the digit counter, and goes to RUN.
  - RUN: each cycle one DIGIT-wide slice passes through the cell chain. The borrow is registered between slices, and the result slice is shifted into the result register. The counter increments each cycle. After slice N-1 (N = WIDTH/DIGIT), the state goes to DONE.
  - DONE: lasts one cycle with done=1. start=1 here is accepted: capture, then go to RUN. Otherwise go to IDLE.
- start in RUN is ignored and is neither queued nor flagged.
- Width rules:
  - The counter is clog2(N) bits, minimum 1.
  - diff is the exact WIDTH-bit two's-complement result.
  - bout=1 iff the unsigned value a < b + bin.
- diff, bout and ovf update only on the edge entering DONE. Partial results are never visible on the outputs.
- Reset, including mid-operation:
  - state goes to IDLE and busy, done, diff, bout and ovf go to 0.
  - The in-flight operation is discarded and no done is produced.

## Timing
- An accepted start at edge E0 gives busy=1 after E0 and done=1 after edge E0+N, for one cycle. diff, bout and ovf are valid from that same edge.
- busy is low in the DONE cycle.
- Back-to-back: a start during done is accepted at that edge. Throughput is one result per N+1 cycles.
- DIGIT=WIDTH gives N=1: the result appears 1 cycle after start.
- No combinational path from inputs to outputs.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - The ovf port exists.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), computed from the captured operands and the final diff. This is exact including bin.
  - ovf is registered alongside diff.
- SERIAL_SUB_OVF_EN undefined: no ovf port, no related logic. All other behaviour is identical.

## Structure
- Package serial_sub_pkg holds:
  - state encoding typedef (IDLE, RUN, DONE);
  - a function returning N from WIDTH and DIGIT;
  - a counter-width helper.
- Sub-module full_sub_cell: one-bit combinational full subtractor.
  - Inputs: x, y, bi. Outputs: d, bo.
  - d = x^y^bi; bo = (~x&y) | (~(x^y)&bi).
  - Instantiated DIGIT times in a generate chain.
- The top level owns all registers, the FSM and elaboration-time parameter checks.

## Test plan
- WIDTH=8, DIGIT=1: a=8'h05, b=8'h03, bin=0 -> done exactly 8 cycles after start; diff=8'h02, bout=0, ovf=0.
- WIDTH=8, DIGIT=1: a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1, ovf=0.
- WIDTH=8, DIGIT=1, with OVF_EN: a=8'h80, b=8'h00, bin=1 -> diff=8'h7F, bout=0, ovf=1.
- WIDTH=8, DIGIT=1, with OVF_EN: a=8'h7F, b=8'hFF, bin=0 -> diff=8'h80, ovf=1.
- Handshake: start pulsed in RUN -> ignored; start held in the done cycle with a=8'h10, b=8'h01 -> second done 8 cycles later with diff=8'h0F.
- rst_n low for 1 cycle midway through an operation -> all outputs 0 and no done.
- WIDTH=16, DIGIT=4: a=16'h1234, b=16'h0235 -> diff=16'h0FFF, bout=0, done 4 cycles after start.
